// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment scan driver with shadow register,
// hex decode, leading-zero blanking and display enable.
//
// Ports:
//   clk      : clock, all state updates on its rising edge
//   rst      : synchronous active-high reset
//   value    : 4*NDIG hex digits, digit 0 in value[3:0] (rightmost)
//   load     : captures value into the shadow register
//   lz_blank : blank leading zero digits (digit 0 is never blanked)
//   en       : display enable; while low, the scan freezes and outputs go dark
//   SSeg     : registered active-low segments {g,f,e,d,c,b,a}
//   an       : registered active-low digit selects
module sseg_scan_driver #(
  parameter int NDIG    = 4,
  parameter int CLK_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] value,
  input  logic              load,
  input  logic              lz_blank,
  input  logic              en,
  output logic [6:0]        SSeg,
  output logic [NDIG-1:0]   an
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [PW-1:0] PCNT_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NDIG - 1);
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;

  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [6:0]        sseg_q, sseg_d;
  logic [NDIG-1:0]   an_q, an_d;

  logic       tick;
  logic       blank;
  logic [3:0] cur_dig;
  logic [6:0] cur_seg;

  // Hex to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_OFF;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b0100111;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000100;
      4'hF: s = 7'b0001110;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Digit currently selected by the scan index.
  always_comb begin
    cur_dig = 4'd0;
    for (int j = 0; j < NDIG; j++) begin
      if (IW'(j) == idx_q) cur_dig = shadow_q[4*j +: 4];
    end
  end

  // Blank when this digit and every more significant one are zero;
  // digit 0 always shows so an all-zero value reads "0".
  always_comb begin
    blank = lz_blank && (idx_q != '0);
    for (int j = 0; j < NDIG; j++) begin
      if (j >= int'(idx_q) && shadow_q[4*j +: 4] != 4'd0) blank = 1'b0;
    end
  end

  assign cur_seg = seg_dec(cur_dig);
  assign tick    = en && (pcnt_q == PCNT_MAX);

  always_comb begin
    pcnt_d   = pcnt_q;
    idx_d    = idx_q;
    shadow_d = load ? value : shadow_q;
    sseg_d   = SEG_OFF;
    an_d     = '1;
    if (en) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      an_d   = ~(NDIG'(1) << idx_q);
      sseg_d = blank ? SEG_OFF : cur_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q   <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      sseg_q   <= SEG_OFF;
      an_q     <= '1;
    end else begin
      pcnt_q   <= pcnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      sseg_q   <= sseg_d;
      an_q     <= an_d;
    end
  end

  assign SSeg = sseg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver, NDIG=4, CLK_DIV=4.
// Linear stimulus, immediate assertions at each check point.
module tb_sseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic        en = 1'b0;
  logic [6:0]  SSeg;
  logic [3:0]  an;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] S_OFF = 7'b1111111;
  localparam logic [6:0] S_0   = 7'b1000000;
  localparam logic [6:0] S_1   = 7'b1111001;
  localparam logic [6:0] S_2   = 7'b0100100;
  localparam logic [6:0] S_5   = 7'b0010010;
  localparam logic [6:0] S_A   = 7'b0001000;
  localparam logic [6:0] S_B   = 7'b0000011;
  localparam logic [6:0] S_F   = 7'b0001110;

  sseg_scan_driver #(.NDIG(4), .CLK_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .load(load),
    .lz_blank(lz_blank),
    .en(en),
    .SSeg(SSeg),
    .an(an)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] ea,
                     input logic [6:0] es);
    checks++;
    assert (an === ea) else begin
      failures++;
      $error("FAIL %s an=%b expected=%b", tag, an, ea);
    end
    checks++;
    assert (SSeg === es) else begin
      failures++;
      $error("FAIL %s SSeg=%b expected=%b", tag, SSeg, es);
    end
  endtask

  // Reset, then load v while disabled so the scan starts at idx 0, pcnt 0.
  task automatic restart_with(input logic [15:0] v);
    rst = 1'b1; en = 1'b0; load = 1'b0;
    step();
    rst = 1'b0; value = v; load = 1'b1;
    step();
    chk("load_dis", 4'b1111, S_OFF);
    load = 1'b0; en = 1'b1;
  endtask

  logic [3:0] an_tab [4];
  logic [6:0] exp_seg [4];

  initial begin
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101;
    an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

    // Reset scenario
    step(); step();
    chk("reset", 4'b1111, S_OFF);
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_d0", 4'b1110, S_0);
    end
    step();
    chk("post_rst_d1", 4'b1101, S_0);

    // Decode scenario
    restart_with(16'h1A2F);
    exp_seg[0] = S_F; exp_seg[1] = S_2;
    exp_seg[2] = S_A; exp_seg[3] = S_1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("decode", an_tab[i/4], exp_seg[i/4]);
    end

    // Leading-zero scenario
    lz_blank = 1'b1;
    restart_with(16'h0050);
    exp_seg[0] = S_0; exp_seg[1] = S_5;
    exp_seg[2] = S_OFF; exp_seg[3] = S_OFF;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("lz_0050", an_tab[i/4], exp_seg[i/4]);
    end
    restart_with(16'h0000);
    exp_seg[1] = S_OFF;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("lz_0000", an_tab[i/4], exp_seg[i/4]);
    end
    lz_blank = 1'b0;

    // Enable scenario: 8 edges cover idx 0,1; 9th is first of idx 2.
    restart_with(16'h1A2F);
    for (int i = 0; i < 9; i++) step();
    chk("en_pre", 4'b1011, S_A);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("en_off", 4'b1111, S_OFF);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_resume", 4'b1011, S_A);
    end
    step();
    chk("en_next", 4'b0111, S_1);

    // Shadow scenario
    restart_with(16'h1A2F);
    value = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_load", 4'b1110, S_F);
    end
    value = 16'h00B5; load = 1'b1;
    step();
    chk("load_tick", 4'b1110, S_F);
    load = 1'b0;
    step();
    chk("load_new", 4'b1101, S_B);

    // Mid-operation reset at idx 3
    for (int i = 0; i < 8; i++) step();
    chk("pre_rst_d3", 4'b0111, S_0);
    rst = 1'b1;
    step();
    chk("mid_rst", 4'b1111, S_OFF);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_d0", 4'b1110, S_0);
    end
    step();
    chk("rst_d1", 4'b1101, S_0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
